// File: rtl/shared_bus_rr.sv
// shared_bus_rr: round-robin, burst-locked shared bus with a registered, backpressured output.
// Optional macro SHARED_BUS_TIMEOUT_EN force-releases bursts after MAX_BEATS accepted beats.
module shared_bus_rr #(
  parameter int WIDTH     = 8,
  parameter int SOURCES   = 6,
  parameter int MAX_BEATS = 16,
  localparam int IDX_W    = $clog2((SOURCES > 2) ? SOURCES : 2)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [SOURCES-1:0]         req,
  input  logic [SOURCES*WIDTH-1:0]   src_data,
  input  logic [SOURCES-1:0]         src_last,
  output logic [SOURCES-1:0]         src_ack,
  output logic [SOURCES-1:0]         gnt,
  output logic [WIDTH-1:0]           out_data,
  output logic [IDX_W-1:0]           out_src,
  output logic                       out_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       timeout
);

  typedef enum logic {S_IDLE = 1'b0, S_OWNED = 1'b1} state_t;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_owner, r_ptr, w_pick, w_owner_inc;
  logic [SOURCES-1:0] r_gnt, w_ack;
  logic [WIDTH-1:0]   r_data;
  logic [IDX_W-1:0]   r_src;
  logic               r_last, r_valid;
  logic               w_accept, w_release, w_force;

  // First requester at or after start, searching upward and wrapping modulo SOURCES.
  function automatic logic [IDX_W-1:0] first_req(input logic [SOURCES-1:0] rq,
                                                 input logic [IDX_W-1:0]   start);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = start;
    found = 1'b0;
    for (int k = 0; k < SOURCES; k++) begin
      idx = int'(start) + k;
      if (idx >= SOURCES) idx = idx - SOURCES;
      if (!found && rq[IDX_W'(idx)]) begin
        pick  = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign w_pick      = first_req(req, r_ptr);
  assign w_owner_inc = (r_owner == IDX_W'(SOURCES - 1)) ? '0 : r_owner + 1'b1;
  assign w_accept    = (r_state == S_OWNED) && req[r_owner] && (!r_valid || out_ready);
  assign w_release   = w_accept && (src_last[r_owner] || w_force);

`ifdef SHARED_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  logic [CNT_W-1:0] r_beats;
  logic             r_timeout;

  // The MAX_BEATS-th accepted beat without last ends the burst as if it were last.
  assign w_force = w_accept && !src_last[r_owner] && (r_beats == CNT_W'(MAX_BEATS - 1));
  assign timeout = r_timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beats   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_force;
      if (w_release)     r_beats <= '0;
      else if (w_accept) r_beats <= r_beats + 1'b1;
    end
  end
`else
  assign w_force = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (|req)     w_state_nxt = S_OWNED;
      S_OWNED: if (w_release) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_ack          = '0;
    w_ack[r_owner] = w_accept;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner <= '0;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_data  <= '0;
      r_src   <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      if (r_state == S_IDLE && |req) begin
        r_owner <= w_pick;
        r_gnt   <= SOURCES'(1) << w_pick;
      end
      if (w_release) begin
        r_gnt <= '0;
        r_ptr <= w_owner_inc;
      end
      // Output register: load on accept, drain when the sink takes the beat.
      if (w_accept) begin
        r_data  <= src_data[int'(r_owner) * WIDTH +: WIDTH];
        r_last  <= src_last[r_owner];
        r_src   <= r_owner;
        r_valid <= 1'b1;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign src_ack   = w_ack;
  assign gnt       = r_gnt;
  assign out_data  = r_data;
  assign out_src   = r_src;
  assign out_last  = r_last;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_shared_bus_rr.sv
// Randomized bench for shared_bus_rr against a cycle-level reference of the bus rules.
module tb_shared_bus_rr;
  localparam int WIDTH     = 8;
  localparam int SOURCES   = 6;
  localparam int MAX_BEATS = 4;
  localparam int IDX_W     = 3;
`ifdef SHARED_BUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [SOURCES-1:0]       req = '0;
  logic [SOURCES*WIDTH-1:0] src_data = '0;
  logic [SOURCES-1:0]       src_last = '0;
  logic [SOURCES-1:0]       src_ack;
  logic [SOURCES-1:0]       gnt;
  logic [WIDTH-1:0]         out_data;
  logic [IDX_W-1:0]         out_src;
  logic                     out_last;
  logic                     out_valid;
  logic                     out_ready = 1'b1;
  logic                     timeout;

  always #5 clk = ~clk;

  shared_bus_rr #(.WIDTH(WIDTH), .SOURCES(SOURCES), .MAX_BEATS(MAX_BEATS)) dut (
    .clk(clk), .rst(rst), .req(req), .src_data(src_data), .src_last(src_last),
    .src_ack(src_ack), .gnt(gnt), .out_data(out_data), .out_src(out_src),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready), .timeout(timeout)
  );

  int n_checks = 0;
  int n_errs   = 0;

  // Reference: who owns the bus (if anyone), the rotation pointer, beats in this burst,
  // and the beat currently held for the sink.
  bit               m_own   = 1'b0;
  int               m_owner = 0;
  int               m_ptr   = 0;
  int               m_beats = 0;
  bit               m_ov    = 1'b0;
  bit               m_ol    = 1'b0;
  bit               m_to    = 1'b0;
  logic [WIDTH-1:0] m_od    = '0;
  int               m_os    = 0;
  logic [SOURCES-1:0] cur_ack = '0;
  int               rem[SOURCES];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [SOURCES-1:0] exp_ack();
    logic [SOURCES-1:0] a;
    a = '0;
    if (m_own && req[m_owner] && (!m_ov || out_ready)) a[m_owner] = 1'b1;
    return a;
  endfunction

  task automatic model_edge();
    logic [SOURCES-1:0] acc;
    bit was_idle;
    bit nto;
    acc      = exp_ack();
    was_idle = !m_own;
    nto      = 1'b0;
    if (rst) begin
      m_own = 0; m_owner = 0; m_ptr = 0; m_beats = 0;
      m_ov = 0; m_ol = 0; m_to = 0; m_od = '0; m_os = 0;
      return;
    end
    if (acc != '0) begin
      m_od = src_data[m_owner*WIDTH +: WIDTH];
      m_ol = src_last[m_owner];
      m_os = m_owner;
      m_ov = 1'b1;
      m_beats++;
      if (src_last[m_owner] || (TO_EN && m_beats == MAX_BEATS)) begin
        nto     = TO_EN && !src_last[m_owner];
        m_own   = 1'b0;
        m_ptr   = (m_owner + 1) % SOURCES;
        m_beats = 0;
      end
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    if (was_idle && req != '0) begin
      for (int k = 0; k < SOURCES; k++) begin
        if (!m_own && req[(m_ptr + k) % SOURCES]) begin
          m_owner = (m_ptr + k) % SOURCES;
          m_own   = 1'b1;
        end
      end
    end
    m_to = nto;
  endtask

  task automatic check_regs();
    logic [SOURCES-1:0] eg;
    eg = m_own ? (SOURCES'(1) << m_owner) : '0;
    check_eq("gnt", 32'(gnt), 32'(eg));
    check_eq("out_valid", 32'(out_valid), 32'(m_ov));
    check_eq("out_data", 32'(out_data), 32'(m_od));
    check_eq("out_src", 32'(out_src), m_os);
    check_eq("out_last", 32'(out_last), 32'(m_ol));
    check_eq("timeout", 32'(timeout), 32'(m_to));
  endtask

  // Inputs are already driven; check the combinational ack, clock once, check registers.
  task automatic step();
    #1;
    cur_ack = exp_ack();
    check_eq("src_ack", 32'(src_ack), 32'(cur_ack));
    @(posedge clk);
    model_edge();
    #1;
    check_regs();
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; src_last = '0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < SOURCES; i++) rem[i] = 0;
    @(posedge clk);
    #1;
    do_reset();

    // Single-beat burst from source 2.
    req = 6'b000100; src_last = 6'b000100; src_data[2*WIDTH +: WIDTH] = 8'hA5; out_ready = 1'b1;
    step();
    check_eq("a5_gnt", 32'(gnt), 32'h04);
    step();
    check_eq("a5_valid", 32'(out_valid), 32'h1);
    check_eq("a5_data", 32'(out_data), 32'hA5);
    check_eq("a5_src", 32'(out_src), 32'h2);
    check_eq("a5_release", 32'(gnt), 32'h0);
    req = '0; src_last = '0;
    step();

    // Sources 0 and 3 alternate with one dead cycle between bursts.
    do_reset();
    req = 6'b001001; src_last = 6'b001001;
    step();
    check_eq("rr_first", 32'(gnt), 32'h01);
    step();
    check_eq("rr_dead", 32'(gnt), 32'h00);
    step();
    check_eq("rr_second", 32'(gnt), 32'h08);
    step();
    step();
    check_eq("rr_wrap", 32'(gnt), 32'h01);
    req = '0; src_last = '0;
    step();
    step();

`ifdef SHARED_BUS_TIMEOUT_EN
    // Source 0 streams without last; source 1 waits its turn.
    do_reset();
    req = 6'b000011; src_last = '0;
    for (int b = 0; b < 5; b++) step();
    check_eq("to_pulse", 32'(timeout), 32'h1);
    check_eq("to_last", 32'(out_last), 32'h0);
    step();
    check_eq("to_next_gnt", 32'(gnt), 32'h02);
    check_eq("to_pulse_end", 32'(timeout), 32'h0);
    req = '0;
    step();
`endif

    // Random bursts, request drops, sink backpressure and occasional reset.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < SOURCES; i++) begin
        if (cur_ack[i]) begin
          rem[i]--;
          src_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
        if (rem[i] == 0 && $urandom_range(0, 3) == 0) rem[i] = int'($urandom_range(1, 7));
        req[i]      = (rem[i] != 0) && ($urandom_range(0, 9) != 0);
        src_last[i] = (rem[i] == 1);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
